// File: rtl/seq_divider.sv
// Iterative unsigned divider. It uses non-restoring division and produces one quotient bit per clock.
// Valid/ready handshakes on the operand and result sides let it sit between pipeline registers.
module seq_divider #(
    parameter int DATA_WIDTH = 18
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder,
    output logic                  div_by_zero
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high.
    // The producer keeps valid and its data steady until that edge.
    // Readiness never depends combinationally on the opposite valid.

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [CW-1:0]         count;
    logic [DATA_WIDTH:0]   p_reg;
    logic [DATA_WIDTH-1:0] q_reg;
    logic [DATA_WIDTH-1:0] d_reg;
    logic [DATA_WIDTH:0]   d_ext;
    logic [DATA_WIDTH:0]   p_shift;
    logic [DATA_WIDTH:0]   p_step;
    logic [DATA_WIDTH:0]   p_fix;
    logic                  zero_div;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign zero_div  = (divisor == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (in_valid) state_next = zero_div ? DONE : CALC;
            CALC: if (count == '0) state_next = FIX;
            FIX:  state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The add/subtract choice uses the sign of P from before the shift.
    // Intermediate wrap in DATA_WIDTH+1 bits is harmless because the result always fits.
    always_comb begin
        d_ext   = {1'b0, d_reg};
        p_shift = {p_reg[DATA_WIDTH-1:0], q_reg[DATA_WIDTH-1]};
        p_step  = p_reg[DATA_WIDTH] ? (p_shift + d_ext) : (p_shift - d_ext);
        p_fix   = p_reg[DATA_WIDTH] ? (p_reg + d_ext) : p_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= '0;
            p_reg       <= '0;
            q_reg       <= '0;
            d_reg       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        d_reg <= divisor;
                        q_reg <= dividend;
                        p_reg <= '0;
                        count <= CW'(DATA_WIDTH - 1);
                        if (zero_div) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    p_reg <= p_step;
                    q_reg <= {q_reg[DATA_WIDTH-2:0], ~p_step[DATA_WIDTH]};
                    if (count != '0) count <= count - CW'(1);
                end
                FIX: begin
                    quotient    <= q_reg;
                    remainder   <= p_fix[DATA_WIDTH-1:0];
                    div_by_zero <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
